bcd_hex_display: RTL

Registered 4-digit seven-segment driver that sits directly downstream of the 16-bit binary-to-BCD converter. It captures the four BCD digits on a load strobe and encodes them to active-low segment patterns for the board HEX displays. It supports leading-zero blanking, an overflow indication (value > 9999) and a free-running blink.

---
 rtl/bcd_hex_display.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/bcd_hex_display.sv
// rtl/bcd_hex_display.sv - registered 4-digit BCD to active-low seven-segment driver
module bcd_hex_display #(
  parameter int BLINK_DIV = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] bcd3,
  input  logic [3:0] bcd2,
  input  logic [3:0] bcd1,
  input  logic [3:0] bcd0,
  input  logic       ovf,
  input  logic       blank_lz,
  input  logic       blink_en,
  output logic [6:0] hex3,
  output logic [6:0] hex2,
  output logic [6:0] hex1,
  output logic [6:0] hex0
);

  localparam int CW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(BLINK_DIV - 1);

  // Segment patterns, active-low, bit order g..a
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Holding registers for the captured value
  logic [3:0] d3_q, d2_q, d1_q, d0_q;
  logic       h_ovf_q;

  // Blink timer
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ph_q, ph_d;

  // Registered display outputs
  logic [6:0] hex3_q, hex2_q, hex1_q, hex0_q;
  logic [6:0] hex3_d, hex2_d, hex1_d, hex0_d;

  // Leading-zero blanking chain, thousands digit first
  logic bl3, bl2, bl1;

  // Digits 10..15 are not valid BCD and show a dash
  function automatic logic [6:0] seg_encode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

  // Capture digits and overflow flag on the load strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d3_q    <= 4'd0;
      d2_q    <= 4'd0;
      d1_q    <= 4'd0;
      d0_q    <= 4'd0;
      h_ovf_q <= 1'b0;
    end else if (load) begin
      d3_q    <= bcd3;
      d2_q    <= bcd2;
      d1_q    <= bcd1;
      d0_q    <= bcd0;
      h_ovf_q <= ovf;
    end
  end

  // Blink timer next state: a load restarts the on phase so new values show at once
  always_comb begin
    cnt_d = cnt_q;
    ph_d  = ph_q;
    if (load) begin
      cnt_d = '0;
      ph_d  = 1'b0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      ph_d  = ~ph_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Blink timer state, free-running regardless of blink_en
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      ph_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ph_q  <= ph_d;
    end
  end

  // Decode held digits with priority blink-off, overflow, invalid, blanking, normal
  always_comb begin
    bl3 = blank_lz && (d3_q == 4'd0);
    bl2 = bl3 && (d2_q == 4'd0);
    bl1 = bl2 && (d1_q == 4'd0);
    hex3_d = SEG_BLANK;
    hex2_d = SEG_BLANK;
    hex1_d = SEG_BLANK;
    hex0_d = SEG_BLANK;
    if (blink_en && ph_q) begin
      hex3_d = SEG_BLANK;
      hex2_d = SEG_BLANK;
      hex1_d = SEG_BLANK;
      hex0_d = SEG_BLANK;
    end else if (h_ovf_q) begin
      hex3_d = SEG_DASH;
      hex2_d = SEG_DASH;
      hex1_d = SEG_DASH;
      hex0_d = SEG_DASH;
    end else begin
      // Blanking only ever triggers on a zero digit, so invalid digits keep their dash
      hex3_d = bl3 ? SEG_BLANK : seg_encode(d3_q);
      hex2_d = bl2 ? SEG_BLANK : seg_encode(d2_q);
      hex1_d = bl1 ? SEG_BLANK : seg_encode(d1_q);
      hex0_d = seg_encode(d0_q);
    end
  end

  // Output registers, blank while in reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hex3_q <= SEG_BLANK;
      hex2_q <= SEG_BLANK;
      hex1_q <= SEG_BLANK;
      hex0_q <= SEG_BLANK;
    end else begin
      hex3_q <= hex3_d;
      hex2_q <= hex2_d;
      hex1_q <= hex1_d;
      hex0_q <= hex0_d;
    end
  end

  assign hex3 = hex3_q;
  assign hex2 = hex2_q;
  assign hex1 = hex1_q;
  assign hex0 = hex0_q;

endmodule
